// File: rtl/poly_stream_loader.sv
// Streams one polynomial into NUM_BANKS row-rotated banks, then launches the NTT core and waits for it to finish.
// Optional coefficient range check against Q: define COEF_RANGE_CHECK_EN.
module poly_stream_loader #(
   parameter int DATA_WIDTH = 12,
   parameter int NUM_BANKS  = 8,
   parameter int N          = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int Q          = 3329
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load_go,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_WIDTH-1:0]           s_data,
   output logic                            wr_en,
   output logic [ADDR_WIDTH-1:0]           wr_addr,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data_bus,
   output logic                            ntt_start,
   input  logic                            ntt_finish,
   output logic                            busy,
   output logic                            done,
   output logic                            range_err
);

   localparam int ROWS  = N / NUM_BANKS;
   localparam int COL_W = $clog2(NUM_BANKS);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] FILL      = 2'd1;
   localparam logic [1:0] LAUNCH    = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   logic [1:0]                      state;
   logic [COL_W-1:0]                col;
   logic [ROW_W-1:0]                row;
   logic [COL_W-1:0]                row_lo;
   logic [DATA_WIDTH-1:0]           row_buf  [NUM_BANKS];
   logic [DATA_WIDTH-1:0]           full_row [NUM_BANKS];
   logic [NUM_BANKS*DATA_WIDTH-1:0] rotated;
   logic                            hs;
   logic                            row_done;
   logic                            last_row;

   assign s_ready  = (state == FILL);
   assign busy     = (state != IDLE);
   assign hs       = s_valid & s_ready;
   assign row_done = hs && (col == COL_W'(NUM_BANKS - 1));
   assign last_row = (row == ROW_W'(ROWS - 1));
   assign row_lo   = COL_W'(row);

   // The completing coefficient bypasses the buffer so the row is written the very next cycle.
   always_comb begin
      rotated = '0;
      for (int c = 0; c < NUM_BANKS; c++) begin
         full_row[c] = (c == NUM_BANKS - 1) ? s_data : row_buf[c];
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         rotated[b*DATA_WIDTH +: DATA_WIDTH] = full_row[COL_W'(b) - row_lo];
      end
   end

   // NOTE: the row buffer is deliberately not reset; a partial row is never written out, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (hs) row_buf[col] <= s_data;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data_bus <= '0;
         ntt_start   <= 1'b0;
         done        <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         ntt_start <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (load_go) begin
                  state <= FILL;
                  row   <= '0;
                  col   <= '0;
               end
            end
            FILL: begin
               if (hs) begin
                  col <= col + 1'b1;
                  if (row_done) begin
                     row         <= row + 1'b1;
                     wr_en       <= 1'b1;
                     wr_addr     <= ADDR_WIDTH'(row);
                     wr_data_bus <= rotated;
                     if (last_row) state <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               ntt_start <= 1'b1;
               state     <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (ntt_finish) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COEF_RANGE_CHECK_EN
   localparam logic [DATA_WIDTH:0] Q_EXT = (DATA_WIDTH + 1)'(Q);

   // Sticky until the next accepted load; out-of-range values are still written unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         range_err <= 1'b0;
      end else if (state == IDLE && load_go) begin
         range_err <= 1'b0;
      end else if (hs && ({1'b0, s_data} >= Q_EXT)) begin
         range_err <= 1'b1;
      end
   end
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: doc/poly_stream_loader.md
Name: poly_stream_loader

Overview:
- Upstream feeder for the multi-lane NTT top. Accepts a polynomial one coefficient per handshake and packs each group of NUM_BANKS coefficients into a row.
- Writes each row to all banks in one cycle through a skewed, conflict-free placement: bank rotation by row index.
- After the last row, issues the one-cycle start pulse to the NTT core, then waits for its finish pulse.

Parameters:
- DATA_WIDTH, 12, coefficient width.
- NUM_BANKS, 8, bank count (2*P); power of two.
- N, 256, coefficients per polynomial; multiple of NUM_BANKS.
- ADDR_WIDTH, 8, bank address width; must be >= log2(N/NUM_BANKS).
- Q, 3329, modulus used by the optional range check.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- load_go  in  1  pulse; starts a load when IDLE.
- s_valid  in  1  coefficient valid.
- s_ready  out  1  loader can accept a coefficient.
- s_data  in  DATA_WIDTH  coefficient, natural order k=0..N-1.
- wr_en  out  1  bank write strobe, common to all banks.
- wr_addr  out  ADDR_WIDTH  bank-internal row address, common to all banks.
- wr_data_bus  out  NUM_BANKS*DATA_WIDTH  slice b (bits b*DATA_WIDTH+:DATA_WIDTH) goes to bank b.
- ntt_start  out  1  one-cycle start pulse to the NTT core.
- ntt_finish  in  1  finish pulse from the NTT core.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when ntt_finish is observed.
- range_err  out  1  sticky error flag; only present with the optional feature.

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters 0. Outputs s_ready=0, wr_en=0, wr_addr=0, wr_data_bus=0, ntt_start=0, busy=0, done=0, range_err=0.
- Reset mid-operation aborts immediately. Partial rows are discarded. No ntt_start is issued.
- States: IDLE, FILL, LAUNCH, WAIT_DONE.
  - IDLE -> FILL on load_go=1; row=0, col=0.
  - FILL: s_ready=1 every cycle, no bubbles. A handshake (s_valid & s_ready) stores s_data at column col.
  - col increments per handshake; it wraps at NUM_BANKS-1, and the wrap increments row.
  - The handshake that takes col=NUM_BANKS-1 completes the row. Next cycle: wr_en=1, wr_addr=row, wr_data_bus = rotated row.
  - Rotation: bank b gets the coefficient at column (b - row) mod NUM_BANKS. Equivalently, coefficient k lands in bank (k + k/NUM_BANKS) mod NUM_BANKS at address k/NUM_BANKS.
  - wr_en is 1 for exactly one cycle per completed row. wr_data_bus and wr_addr hold their last value when wr_en=0.
  - FILL -> LAUNCH on completion of row N/NUM_BANKS-1. s_ready drops the cycle after the final handshake.
  - LAUNCH: ntt_start=1 for exactly one cycle, in the cycle after the final wr_en. Then -> WAIT_DONE.
  - WAIT_DONE: s_ready=0. On ntt_finish=1: done=1 the next cycle, -> IDLE.
  - ntt_finish in any other state is ignored.
- load_go outside IDLE is ignored.
- s_valid while s_ready=0 is not consumed; the coefficient is dropped from the loader's view and no state changes.
- Latency:
  - Last coefficient handshake -> final wr_en: 1 cycle.
  - Final wr_en -> ntt_start: 1 cycle.
  - With continuous s_valid, a full load takes N handshake cycles + 2 cycles.
- Counters: col is log2(NUM_BANKS) bits; row is log2(N/NUM_BANKS) bits. Wrap is by natural overflow.

Optional Feature:
- COEF_RANGE_CHECK_EN defined: each accepted coefficient is compared with Q.
  - s_data >= Q sets range_err=1. The value is still written unchanged.
  - range_err clears only on reset or on the next load_go accepted in IDLE.
- Undefined: no comparator is built; range_err is tied to 0.

Test Plan:
- Reset: hold rst=0 with s_valid=1 and load_go=1 -> all outputs 0, state stays IDLE. After release -> outputs stay 0 until load_go.
- Full load with N=256, NUM_BANKS=8, s_data=k, s_valid continuous:
  - 32 wr_en pulses at wr_addr 0..31.
  - Row 0 slices = 0..7.
  - Row 1 slice0=15, slice1=8.
  - Bank b, address r holds 8r+((b-r) mod 8).
  - ntt_start exactly 1 cycle after the 32nd wr_en. busy=1 throughout.
- Bursty s_valid (random 50% gaps) -> identical bank contents to the continuous case. wr_en pulses only after the 8th handshake of each row.
- Handshake and control after loading:
  - load_go pulses and s_valid during WAIT_DONE -> no writes, no state change.
  - ntt_finish -> done pulse next cycle, busy=0, s_ready=0. A second load_go then restarts at row 0.
- Reset asserted after 100 coefficients -> immediate IDLE, no ntt_start. A subsequent full load -> correct contents from address 0.
- COEF_RANGE_CHECK_EN defined:
  - Feed s_data=3329 at k=5 -> range_err=1 the cycle after that handshake, held until the next load_go.
  - A load with all coefficients < 3329 -> range_err=0.
